// File: rtl/geri_yaz_hakem_if.sv
// ============================================================================
// Module   : geri_yaz_hakem_if
// Brief    : Write-back arbiter bus: pipeline result, late channels, RF port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface geri_yaz_hakem_if #(
    parameter int XLEN  = 32,
    parameter int PS_W  = 18,
    parameter int N_GEC = 2
);
    logic                    yrt_gecerli_i;
    logic                    yrt_hazir_o;
    logic [4:0]              yrt_rd_adres_i;
    logic [XLEN-1:0]         yrt_rd_deger_i;
    logic [2:0]              yrt_mikroislem_i;
    logic [PS_W-1:0]         yrt_ps_artmis_i;
    logic [N_GEC-1:0]        gec_gecerli_i;
    logic [N_GEC-1:0]        gec_hazir_o;
    logic [5*N_GEC-1:0]      gec_rd_adres_i;
    logic [XLEN*N_GEC-1:0]   gec_deger_i;
    logic [4:0]              cyo_yaz_adres_o;
    logic [XLEN-1:0]         cyo_yaz_deger_o;
    logic                    cyo_yaz_yazmac_o;
    logic                    hata_o;

    modport slave (
        input  yrt_gecerli_i, yrt_rd_adres_i, yrt_rd_deger_i, yrt_mikroislem_i,
               yrt_ps_artmis_i, gec_gecerli_i, gec_rd_adres_i, gec_deger_i,
        output yrt_hazir_o, gec_hazir_o, cyo_yaz_adres_o, cyo_yaz_deger_o,
               cyo_yaz_yazmac_o, hata_o
    );

    modport master (
        output yrt_gecerli_i, yrt_rd_adres_i, yrt_rd_deger_i, yrt_mikroislem_i,
               yrt_ps_artmis_i, gec_gecerli_i, gec_rd_adres_i, gec_deger_i,
        input  yrt_hazir_o, gec_hazir_o, cyo_yaz_adres_o, cyo_yaz_deger_o,
               cyo_yaz_yazmac_o, hata_o
    );
endinterface

`default_nettype wire

// File: rtl/geri_yaz_hakem.sv
// ============================================================================
// Module   : geri_yaz_hakem
// Brief    : Single-port register-file write-back arbiter with starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module geri_yaz_hakem #(
    parameter int                     XLEN        = 32,
    parameter int                     PS_W        = 18,
    parameter logic [XLEN-PS_W-2:0]   PS_UST      = 13'h0800,
    parameter int                     N_GEC       = 2,
    parameter int                     BEKLEME_MAX = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    geri_yaz_hakem_if.slave    bus
);

    localparam int                 c_PTR_W   = (N_GEC > 1) ? $clog2(N_GEC) : 1;
    localparam int                 c_SAY_W   = $clog2(BEKLEME_MAX + 1);
    localparam logic [N_GEC-1:0]   c_BIR     = N_GEC'(1);
    localparam logic [c_SAY_W-1:0] c_SAY_MAX = c_SAY_W'(BEKLEME_MAX);

    logic [c_PTR_W-1:0]      r_ptr;
    logic                    r_yazmac;
    logic [4:0]              r_adres;
    logic [XLEN-1:0]         r_deger;
    logic                    r_hata;

    logic                    w_yazan;
    logic [N_GEC-1:0]        w_ac;
    logic [N_GEC-1:0]        w_gec_izin;
    logic                    w_yrt_kabul;
    logic [4:0]              w_gec_adres;
    logic [XLEN-1:0]         w_gec_deger;
    logic [c_PTR_W-1:0]      w_ptr_sonraki;
    logic [N_GEC-1:0]        w_kay_g;
    logic [5*N_GEC-1:0]      w_kay_a;
    logic [XLEN*N_GEC-1:0]   w_kay_d;
    logic                    w_yaz;
    logic [4:0]              w_adres;
    logic [XLEN-1:0]         w_deger;
    logic                    w_hata_kur;

    // First set bit of mask, searching upward from ptr and wrapping.
    function automatic logic [N_GEC-1:0] rr_sec(input logic [N_GEC-1:0] mask,
                                                input logic [c_PTR_W-1:0] ptr);
        logic [N_GEC-1:0] sonuc;
        logic [N_GEC-1:0] kayik;
        logic             bulundu;
        int               idx;
        sonuc   = '0;
        bulundu = 1'b0;
        for (int i = 0; i < N_GEC; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_GEC) idx = idx - N_GEC;
            kayik = mask >> idx;
            if (!bulundu && kayik[0]) begin
                sonuc   = c_BIR << idx;
                bulundu = 1'b1;
            end
        end
        return sonuc;
    endfunction

    assign w_yazan = bus.yrt_gecerli_i && bus.yrt_mikroislem_i[2] && !bus.yrt_mikroislem_i[1]
                     && (bus.yrt_rd_adres_i != 5'd0);

    generate
        for (genvar k = 0; k < N_GEC; k++) begin : g_sayac
            logic [c_SAY_W-1:0] r_sayac;

            assign w_ac[k] = bus.gec_gecerli_i[k] && (r_sayac == c_SAY_MAX);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_sayac <= '0;
                end else if (!bus.gec_gecerli_i[k] || w_gec_izin[k]) begin
                    r_sayac <= '0;
                end else if (r_sayac != c_SAY_MAX) begin
                    r_sayac <= r_sayac + 1'b1;
                end
            end
        end
    endgenerate

    // Starved late channels outrank the pipeline; otherwise the pipeline writer wins.
    always_comb begin
        w_gec_izin  = '0;
        w_yrt_kabul = 1'b0;
        if (!rst_ni) begin
            w_gec_izin  = '0;
            w_yrt_kabul = 1'b0;
        end else if (|w_ac) begin
            w_gec_izin  = rr_sec(w_ac, r_ptr);
            w_yrt_kabul = bus.yrt_gecerli_i && !w_yazan;
        end else if (w_yazan) begin
            w_yrt_kabul = 1'b1;
        end else begin
            w_gec_izin  = rr_sec(bus.gec_gecerli_i, r_ptr);
            w_yrt_kabul = bus.yrt_gecerli_i;
        end
    end

    assign bus.yrt_hazir_o = w_yrt_kabul;
    assign bus.gec_hazir_o = w_gec_izin;

    always_comb begin
        w_gec_adres   = '0;
        w_gec_deger   = '0;
        w_ptr_sonraki = r_ptr;
        w_kay_g       = '0;
        w_kay_a       = '0;
        w_kay_d       = '0;
        for (int k = 0; k < N_GEC; k++) begin
            w_kay_g = w_gec_izin >> k;
            if (w_kay_g[0]) begin
                w_kay_a       = bus.gec_rd_adres_i >> (5 * k);
                w_kay_d       = bus.gec_deger_i >> (XLEN * k);
                w_gec_adres   = w_kay_a[4:0];
                w_gec_deger   = w_kay_d[XLEN-1:0];
                w_ptr_sonraki = (k == N_GEC - 1) ? '0 : c_PTR_W'(k + 1);
            end
        end
    end

    // A late grant to x0 still consumes the slot but leaves adres/deger untouched.
    always_comb begin
        w_yaz   = 1'b0;
        w_adres = r_adres;
        w_deger = r_deger;
        if (|w_gec_izin) begin
            if (w_gec_adres != 5'd0) begin
                w_yaz   = 1'b1;
                w_adres = w_gec_adres;
                w_deger = w_gec_deger;
            end
        end else if (w_yazan && w_yrt_kabul) begin
            w_yaz   = 1'b1;
            w_adres = bus.yrt_rd_adres_i;
            w_deger = bus.yrt_mikroislem_i[0] ? {PS_UST, bus.yrt_ps_artmis_i, 1'b0}
                                              : bus.yrt_rd_deger_i;
        end
    end

    assign w_hata_kur = w_yrt_kabul && bus.yrt_mikroislem_i[2] && bus.yrt_mikroislem_i[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr    <= '0;
            r_yazmac <= 1'b0;
            r_adres  <= '0;
            r_deger  <= '0;
            r_hata   <= 1'b0;
        end else begin
            r_yazmac <= w_yaz;
            r_adres  <= w_adres;
            r_deger  <= w_deger;
            r_hata   <= r_hata || w_hata_kur;
            if (|w_gec_izin) r_ptr <= w_ptr_sonraki;
        end
    end

    assign bus.cyo_yaz_yazmac_o = r_yazmac;
    assign bus.cyo_yaz_adres_o  = r_adres;
    assign bus.cyo_yaz_deger_o  = r_deger;
    assign bus.hata_o           = r_hata;

endmodule

`default_nettype wire
